// File: rtl/im_port_arbiter.sv
// Instruction-memory port arbiter.
// Shares one synchronous-read IM port between the CPU fetch stage and the
// program loader/debug port. It decodes byte addresses into word indices,
// flags misaligned or out-of-range requests, and returns one response per
// grant exactly one cycle later. The loader can take the port exclusively
// (lock), which halts the CPU through cpu_hold.
module im_port_arbiter #(
  parameter int          ADDR_W       = 12,
  parameter logic [31:0] BASE_ADDR    = 32'h0000_3000,
  parameter int          STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  // CPU fetch port (read only)
  input  logic              f_req,
  input  logic [31:0]       f_addr,
  output logic              f_gnt,
  output logic              f_rvalid,
  output logic [31:0]       f_rdata,
  output logic              f_err,
  // Loader / debug port
  input  logic              l_req,
  input  logic              l_we,
  input  logic [31:0]       l_addr,
  input  logic [31:0]       l_wdata,
  input  logic              l_lock,
  output logic              l_gnt,
  output logic              l_rvalid,
  output logic [31:0]       l_rdata,
  output logic              l_err,
  output logic              cpu_hold,
  // IM array port
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [1:0] {
    ARB    = 2'd0,
    DRAIN  = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam int                CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0]  LIMIT = CNT_W'(STARVE_LIMIT);
  // Size of the IM in bytes; offsets at or above this are out of range.
  localparam logic [31:0]       SPAN  = 32'd4 << ADDR_W;

  state_t            state, state_nx;
  logic [CNT_W-1:0]  starve_cnt, cnt_nx;

  logic [31:0]       f_off, l_off;
  logic              f_bad, l_bad;
  logic [ADDR_W-1:0] f_idx, l_idx;

  // Response-side bookkeeping: whether the returning word should be passed on.
  logic              f_take, l_take;

  // Address decode: the wrapping subtraction makes addresses below the base
  // look huge, so a single unsigned compare catches both range violations.
  always_comb begin
    f_off = f_addr - BASE_ADDR;
    l_off = l_addr - BASE_ADDR;
    f_bad = (f_addr[1:0] != 2'b00) || (f_off >= SPAN);
    l_bad = (l_addr[1:0] != 2'b00) || (l_off >= SPAN);
    f_idx = f_off[ADDR_W+1:2];
    l_idx = l_off[ADDR_W+1:2];
  end

  // Arbitration and next-state: fetch first, loader on idle fetch or starvation.
  always_comb begin
    // NOTE: every signal gets a default before the case so no latch is inferred.
    state_nx = state;
    cnt_nx   = starve_cnt;
    f_gnt    = 1'b0;
    l_gnt    = 1'b0;
    case (state)
      ARB: begin
        l_gnt = l_req && (!f_req || (starve_cnt == LIMIT));
        f_gnt = f_req && !l_gnt;
        if (l_req && !l_gnt)
          cnt_nx = (starve_cnt == LIMIT) ? LIMIT : starve_cnt + 1'b1;
        else
          cnt_nx = '0;
        if (l_req && l_lock)
          state_nx = DRAIN;
      end
      DRAIN: begin
        // One empty cycle lets any response granted in ARB come back.
        cnt_nx   = '0;
        state_nx = LOCKED;
      end
      LOCKED: begin
        cnt_nx = '0;
        l_gnt  = l_req;
        if (!l_lock)
          state_nx = ARB;
      end
      default: begin
        cnt_nx   = '0;
        state_nx = ARB;
      end
    endcase
    // Grants are combinational, so they must be suppressed while in reset.
    if (!reset) begin
      f_gnt = 1'b0;
      l_gnt = 1'b0;
    end
  end

  // Memory-side drive from the winner; errored requests never write.
  always_comb begin
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    if (l_gnt) begin
      mem_addr = l_idx;
      mem_we   = l_we && !l_bad;
    end else if (f_gnt) begin
      mem_addr = f_idx;
    end
    if (mem_we)
      mem_wdata = l_wdata;
  end

  // State, starvation counter, hold flag and the one-cycle response pipeline.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments and an async active-low reset.
    if (!reset) begin
      state      <= ARB;
      starve_cnt <= '0;
      cpu_hold   <= 1'b0;
      f_rvalid   <= 1'b0;
      f_err      <= 1'b0;
      f_take     <= 1'b0;
      l_rvalid   <= 1'b0;
      l_err      <= 1'b0;
      l_take     <= 1'b0;
    end else begin
      state      <= state_nx;
      starve_cnt <= cnt_nx;
      cpu_hold   <= (state_nx != ARB);
      f_rvalid   <= f_gnt;
      f_err      <= f_gnt && f_bad;
      f_take     <= f_gnt && !f_bad;
      l_rvalid   <= l_gnt;
      l_err      <= l_gnt && l_bad;
      l_take     <= l_gnt && !l_bad && !l_we;
    end
  end

  // Read data comes straight from the array's registered output.
  assign f_rdata = f_take ? mem_rdata : 32'd0;
  assign l_rdata = l_take ? mem_rdata : 32'd0;

endmodule

// File: tb/tb_im_port_arbiter.sv
// Directed self-checking bench for im_port_arbiter with a behavioural
// synchronous-read IM array attached to the memory port.
module tb_im_port_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        f_req, f_gnt, f_rvalid, f_err;
  logic [31:0] f_addr, f_rdata;
  logic        l_req, l_we, l_lock, l_gnt, l_rvalid, l_err;
  logic [31:0] l_addr, l_wdata, l_rdata;
  logic        cpu_hold;
  logic [11:0] mem_addr;
  logic        mem_we;
  logic [31:0] mem_wdata, mem_rdata;

  int checks = 0;
  int failures = 0;

  logic [31:0] im [0:4095];

  always #5 clk = ~clk;

  // IM array model: registered read, write visible to reads on later cycles.
  always @(posedge clk) begin
    if (mem_we) im[mem_addr] <= mem_wdata;
    mem_rdata <= im[mem_addr];
  end

  im_port_arbiter dut (
    .clk(clk), .reset(reset),
    .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid),
    .f_rdata(f_rdata), .f_err(f_err),
    .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
    .l_lock(l_lock), .l_gnt(l_gnt), .l_rvalid(l_rvalid), .l_rdata(l_rdata),
    .l_err(l_err), .cpu_hold(cpu_hold),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    f_req = 1'b0; f_addr = 32'h0;
    l_req = 1'b0; l_we = 1'b0; l_lock = 1'b0; l_addr = 32'h0;
  endtask

  task automatic load_word(input logic [31:0] a, input logic [31:0] d);
    f_req = 1'b0;
    l_req = 1'b1; l_we = 1'b1; l_addr = a; l_wdata = d;
    step();
    l_req = 1'b0; l_we = 1'b0;
  endtask

  task automatic test_reset();
    f_req = 1'b1; f_addr = 32'h3000;
    l_req = 1'b1; l_we = 1'b1; l_lock = 1'b0; l_addr = 32'h3004; l_wdata = 32'hA5A5A5A5;
    #1 reset = 1'b0;
    #2;
    checks++; if (f_gnt !== 1'b0) begin failures++; $display("FAIL rst_f_gnt act=%0h exp=0", f_gnt); end
    checks++; if (l_gnt !== 1'b0) begin failures++; $display("FAIL rst_l_gnt act=%0h exp=0", l_gnt); end
    checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL rst_mem_we act=%0h exp=0", mem_we); end
    checks++; if (mem_addr !== 12'h0) begin failures++; $display("FAIL rst_mem_addr act=%0h exp=0", mem_addr); end
    checks++; if (mem_wdata !== 32'h0) begin failures++; $display("FAIL rst_mem_wdata act=%0h exp=0", mem_wdata); end
    step(); step();
    checks++; if (f_rvalid !== 1'b0 || l_rvalid !== 1'b0) begin failures++; $display("FAIL rst_rvalid act=%0h%0h exp=00", f_rvalid, l_rvalid); end
    checks++; if (f_err !== 1'b0 || l_err !== 1'b0) begin failures++; $display("FAIL rst_err act=%0h%0h exp=00", f_err, l_err); end
    checks++; if (cpu_hold !== 1'b0) begin failures++; $display("FAIL rst_cpu_hold act=%0h exp=0", cpu_hold); end
    checks++; if (f_rdata !== 32'h0 || l_rdata !== 32'h0) begin failures++; $display("FAIL rst_rdata act=%0h/%0h exp=0/0", f_rdata, l_rdata); end
    idle();
    reset = 1'b1;
    step();
  endtask

  task automatic test_fetch();
    load_word(32'h3000, 32'h3C010001);
    load_word(32'h3004, 32'h34210002);
    load_word(32'h3008, 32'h11223344);
    step();
    f_req = 1'b1; f_addr = 32'h3000;
    #1;
    checks++; if (f_gnt !== 1'b1 || l_gnt !== 1'b0) begin failures++; $display("FAIL fetch_gnt0 act=%0h%0h exp=10", f_gnt, l_gnt); end
    checks++; if (mem_addr !== 12'd0 || mem_we !== 1'b0) begin failures++; $display("FAIL fetch_mem0 addr=%0h we=%0h exp=0/0", mem_addr, mem_we); end
    checks++; if (mem_wdata !== 32'h0) begin failures++; $display("FAIL fetch_wdata_zero act=%0h exp=0", mem_wdata); end
    step();
    checks++; if (f_rvalid !== 1'b1 || f_rdata !== 32'h3C010001) begin failures++; $display("FAIL fetch_rsp0 v=%0h d=%0h exp=1/3c010001", f_rvalid, f_rdata); end
    f_addr = 32'h3004;
    #1;
    checks++; if (f_gnt !== 1'b1 || mem_addr !== 12'd1) begin failures++; $display("FAIL fetch_gnt1 g=%0h a=%0h exp=1/1", f_gnt, mem_addr); end
    step();
    checks++; if (f_rvalid !== 1'b1 || f_rdata !== 32'h34210002 || f_err !== 1'b0) begin failures++; $display("FAIL fetch_rsp1 v=%0h d=%0h e=%0h exp=1/34210002/0", f_rvalid, f_rdata, f_err); end
    f_req = 1'b0;
    step();
    checks++; if (f_rvalid !== 1'b0) begin failures++; $display("FAIL fetch_rvalid_pulse act=%0h exp=0", f_rvalid); end
  endtask

  task automatic test_starvation();
    int lg_cycle;
    lg_cycle = -1;
    f_req = 1'b1; f_addr = 32'h3000;
    l_req = 1'b1; l_we = 1'b0; l_addr = 32'h3008;
    for (int c = 0; c < 5; c++) begin
      #1;
      if (l_gnt === 1'b1 && lg_cycle < 0) lg_cycle = c;
      if (c < 4) begin
        checks++; if (f_gnt !== 1'b1 || l_gnt !== 1'b0) begin failures++; $display("FAIL starve_c%0d f=%0h l=%0h exp=10", c, f_gnt, l_gnt); end
      end else begin
        checks++; if (f_gnt !== 1'b0 || l_gnt !== 1'b1 || mem_addr !== 12'd2) begin failures++; $display("FAIL starve_force f=%0h l=%0h a=%0h exp=0/1/2", f_gnt, l_gnt, mem_addr); end
      end
      step();
    end
    checks++; if (lg_cycle != 4) begin failures++; $display("FAIL starve_cycle act=%0d exp=4", lg_cycle); end
    checks++; if (l_rvalid !== 1'b1 || l_rdata !== 32'h11223344 || f_rvalid !== 1'b0) begin failures++; $display("FAIL starve_rsp lv=%0h ld=%0h fv=%0h exp=1/11223344/0", l_rvalid, l_rdata, f_rvalid); end
    l_req = 1'b0;
    #1;
    checks++; if (f_gnt !== 1'b1) begin failures++; $display("FAIL starve_resume act=%0h exp=1", f_gnt); end
    f_req = 1'b0;
    step(); step();
  endtask

  task automatic test_addr_err();
    logic [31:0] addrs [4];
    logic        errs  [4];
    addrs[0] = 32'h2FFC; errs[0] = 1'b1;
    addrs[1] = 32'h3002; errs[1] = 1'b1;
    addrs[2] = 32'h7000; errs[2] = 1'b1;
    addrs[3] = 32'h6FFC; errs[3] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      f_req = 1'b1; f_addr = addrs[i];
      #1;
      checks++; if (f_gnt !== 1'b1 || mem_we !== 1'b0) begin failures++; $display("FAIL err_gnt%0d g=%0h we=%0h exp=1/0", i, f_gnt, mem_we); end
      step();
      checks++; if (f_rvalid !== 1'b1 || f_err !== errs[i]) begin failures++; $display("FAIL err_rsp%0d v=%0h e=%0h exp=1/%0h", i, f_rvalid, f_err, errs[i]); end
      if (errs[i]) begin
        checks++; if (f_rdata !== 32'h0) begin failures++; $display("FAIL err_rdata%0d act=%0h exp=0", i, f_rdata); end
      end
    end
    f_req = 1'b0;
    l_req = 1'b1; l_we = 1'b1; l_addr = 32'h7000; l_wdata = 32'hCAFEF00D;
    #1;
    checks++; if (l_gnt !== 1'b1 || mem_we !== 1'b0 || mem_wdata !== 32'h0) begin failures++; $display("FAIL err_lwr g=%0h we=%0h wd=%0h exp=1/0/0", l_gnt, mem_we, mem_wdata); end
    step();
    checks++; if (l_rvalid !== 1'b1 || l_err !== 1'b1 || l_rdata !== 32'h0) begin failures++; $display("FAIL err_lrsp v=%0h e=%0h d=%0h exp=1/1/0", l_rvalid, l_err, l_rdata); end
    idle();
    step();
  endtask

  task automatic test_lock();
    f_req = 1'b1; f_addr = 32'h3000;
    l_req = 1'b1; l_lock = 1'b1; l_we = 1'b1; l_addr = 32'h3000; l_wdata = 32'hDEADBEEF;
    #1;
    checks++; if (f_gnt !== 1'b1 || l_gnt !== 1'b0 || cpu_hold !== 1'b0) begin failures++; $display("FAIL lock_detect f=%0h l=%0h h=%0h exp=1/0/0", f_gnt, l_gnt, cpu_hold); end
    step();
    #1;
    checks++; if (cpu_hold !== 1'b1 || f_gnt !== 1'b0 || l_gnt !== 1'b0) begin failures++; $display("FAIL lock_drain h=%0h f=%0h l=%0h exp=1/0/0", cpu_hold, f_gnt, l_gnt); end
    checks++; if (f_rvalid !== 1'b1) begin failures++; $display("FAIL lock_inflight act=%0h exp=1", f_rvalid); end
    step();
    #1;
    checks++; if (cpu_hold !== 1'b1 || f_gnt !== 1'b0 || l_gnt !== 1'b1) begin failures++; $display("FAIL lock_locked h=%0h f=%0h l=%0h exp=1/0/1", cpu_hold, f_gnt, l_gnt); end
    checks++; if (mem_we !== 1'b1 || mem_addr !== 12'd0 || mem_wdata !== 32'hDEADBEEF) begin failures++; $display("FAIL lock_wr0 we=%0h a=%0h d=%0h exp=1/0/deadbeef", mem_we, mem_addr, mem_wdata); end
    step();
    checks++; if (l_rvalid !== 1'b1 || l_rdata !== 32'h0 || l_err !== 1'b0) begin failures++; $display("FAIL lock_wrsp v=%0h d=%0h e=%0h exp=1/0/0", l_rvalid, l_rdata, l_err); end
    l_addr = 32'h4180; l_wdata = 32'h0;
    #1;
    checks++; if (l_gnt !== 1'b1 || f_gnt !== 1'b0 || mem_addr !== 12'd1120 || mem_we !== 1'b1) begin failures++; $display("FAIL lock_wr1 l=%0h f=%0h a=%0d we=%0h exp=1/0/1120/1", l_gnt, f_gnt, mem_addr, mem_we); end
    step();
    l_req = 1'b0; l_lock = 1'b0; l_we = 1'b0;
    #1;
    checks++; if (f_gnt !== 1'b0 || cpu_hold !== 1'b1) begin failures++; $display("FAIL lock_release f=%0h h=%0h exp=0/1", f_gnt, cpu_hold); end
    step();
    #1;
    checks++; if (cpu_hold !== 1'b0 || f_gnt !== 1'b1) begin failures++; $display("FAIL lock_unhold h=%0h f=%0h exp=0/1", cpu_hold, f_gnt); end
    step();
    checks++; if (f_rvalid !== 1'b1 || f_rdata !== 32'hDEADBEEF) begin failures++; $display("FAIL lock_readback v=%0h d=%0h exp=1/deadbeef", f_rvalid, f_rdata); end
    idle();
    step();
  endtask

  task automatic test_reset_mid();
    f_req = 1'b1; f_addr = 32'h3000;
    #1;
    checks++; if (f_gnt !== 1'b1) begin failures++; $display("FAIL midrst_gnt act=%0h exp=1", f_gnt); end
    #1 reset = 1'b0;
    #1;
    checks++; if (f_gnt !== 1'b0 || mem_addr !== 12'h0) begin failures++; $display("FAIL midrst_comb g=%0h a=%0h exp=0/0", f_gnt, mem_addr); end
    step(); step();
    checks++; if (f_rvalid !== 1'b0 || l_rvalid !== 1'b0 || f_rdata !== 32'h0 || cpu_hold !== 1'b0) begin failures++; $display("FAIL midrst_out fv=%0h lv=%0h d=%0h h=%0h exp=0/0/0/0", f_rvalid, l_rvalid, f_rdata, cpu_hold); end
    idle();
    reset = 1'b1;
    step();
    checks++; if (f_rvalid !== 1'b0 || l_rvalid !== 1'b0) begin failures++; $display("FAIL midrst_stale fv=%0h lv=%0h exp=0/0", f_rvalid, l_rvalid); end
    f_req = 1'b1; f_addr = 32'h3000;
    #1;
    checks++; if (f_gnt !== 1'b1) begin failures++; $display("FAIL midrst_refetch_gnt act=%0h exp=1", f_gnt); end
    step();
    checks++; if (f_rvalid !== 1'b1 || f_rdata !== 32'hDEADBEEF) begin failures++; $display("FAIL midrst_refetch v=%0h d=%0h exp=1/deadbeef", f_rvalid, f_rdata); end
    f_req = 1'b0;
    step();
    checks++; if (f_rvalid !== 1'b0) begin failures++; $display("FAIL midrst_pulse act=%0h exp=0", f_rvalid); end
  endtask

  initial begin
    idle();
    l_wdata = 32'h0;
    test_reset();
    test_fetch();
    test_starvation();
    test_addr_err();
    test_lock();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
